// File: rtl/pkt_pkg.sv
// Shared packet-format definitions for the packet transmitter and receiver.
// Holds the framing constants and the common state encoding.
package pkt_pkg;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hAA;
    localparam int         PKT_LEN             = 18;
    // Header and checksum take the two framing bytes around the payload.
    localparam int         PAYLOAD_LEN_DEFAULT = PKT_LEN - 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } pkt_state_t;

endpackage

// File: rtl/pkt_checksum.sv
// Byte-wide XOR accumulator shared by the packet transmitter and receiver.
// A clear takes priority over folding in a byte on the same cycle.
module pkt_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] byte_in,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum ^ byte_in;
        end
    end

endmodule

// File: rtl/packet_transmitter.sv
// Serialises a parallel payload into header, payload (MSB byte first) and
// XOR checksum bytes over a valid/ready byte interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pkt_ready high, waiting for pkt_valid; tx_valid low
// HEADER   | presenting HEADER_BYTE until the sink takes it
// PAYLOAD  | presenting payload byte <index>, MSB byte first
// CHECKSUM | presenting the XOR of all payload bytes
module packet_transmitter
    import pkt_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
    parameter int         PAYLOAD_LEN = PAYLOAD_LEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*PAYLOAD_LEN-1:0] pkt_data,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     pkt_done,
    output logic [15:0]              sent_count
);

    localparam int               IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

    pkt_state_t               state;
    pkt_state_t               state_next;
    logic [8*PAYLOAD_LEN-1:0] payload_reg;
    logic [IDX_W-1:0]         index;
    logic [7:0]               cur_payload_byte;
    logic [7:0]               csum;
    logic                     accept;
    logic                     payload_take;
    logic                     csum_take;

    // The payload register shifts left as bytes leave, so the current byte
    // is always the top one and matches payload byte <index>.
    assign cur_payload_byte = payload_reg[8*PAYLOAD_LEN-1 -: 8];

    assign accept       = (state == IDLE) && pkt_valid;
    assign payload_take = (state == PAYLOAD) && tx_ready;
    assign csum_take    = (state == CHECKSUM) && tx_ready;

    always_comb begin
        state_next = state;
        pkt_ready  = 1'b0;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        unique case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                tx_valid = 1'b1;
                tx_byte  = HEADER_BYTE;
                if (tx_ready) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_valid = 1'b1;
                tx_byte  = cur_payload_byte;
                if (tx_ready && (index == LAST_IDX)) begin
                    state_next = CHECKSUM;
                end
            end
            CHECKSUM: begin
                tx_valid = 1'b1;
                tx_byte  = csum;
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            payload_reg <= '0;
            index       <= '0;
        end else if (accept) begin
            payload_reg <= pkt_data;
            index       <= '0;
        end else if (payload_take) begin
            payload_reg <= payload_reg << 8;
            index       <= (index == LAST_IDX) ? '0 : index + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_done   <= 1'b0;
            sent_count <= 16'h0000;
        end else begin
            pkt_done <= csum_take;
            if (csum_take) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    pkt_checksum u_checksum (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (payload_take),
        .byte_in (cur_payload_byte),
        .sum     (csum)
    );

endmodule

// File: doc/packet_transmitter.md
PACKET_TRANSMITTER -- requirements
Module: packet_transmitter

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hAA, first byte of every packet.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 16, payload bytes per packet; total packet = PAYLOAD_LEN+2 bytes (18).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port pkt_data  input  8*PAYLOAD_LEN  payload; byte 0 = MSB byte [127:120].
REQ-006 SHALL have port pkt_valid  input  1  upstream offers pkt_data.
REQ-007 SHALL have port pkt_ready  output  1  block accepts a packet this cycle.
REQ-008 SHALL have port tx_byte  output  8  serialized byte to the byte sink.
REQ-009 SHALL have port tx_valid  output  1  tx_byte holds a valid byte.
REQ-010 SHALL have port tx_ready  input  1  sink accepts tx_byte this cycle.
REQ-011 SHALL have port pkt_done  output  1  one-cycle pulse after the checksum byte is accepted.
REQ-012 SHALL have port sent_count  output  16  number of completed packets, wrapping.

Function
REQ-013 SHALL implement states IDLE, HEADER, PAYLOAD, CHECKSUM.
REQ-014 SHALL drive pkt_ready=1 only in IDLE; accept a packet on the edge where pkt_valid&&pkt_ready.
REQ-015 SHALL register pkt_data at acceptance; later pkt_data changes SHALL NOT affect the packet in flight.
REQ-016 SHALL move IDLE->HEADER on accept, with tx_valid=1 and tx_byte=HEADER_BYTE the next cycle.
REQ-017 SHALL advance one byte only on a cycle with tx_valid&&tx_ready; byte index counter 0..PAYLOAD_LEN-1.
REQ-018 SHALL hold tx_byte and tx_valid stable while tx_valid&&!tx_ready, for any number of cycles.
REQ-019 SHALL move HEADER->PAYLOAD on header accept; PAYLOAD->CHECKSUM when byte PAYLOAD_LEN-1 is accepted.
REQ-020 SHALL send payload bytes MSB-first: byte i = pkt_data[(PAYLOAD_LEN-1-i)*8 +: 8].
REQ-021 SHALL compute the checksum as the 8-bit XOR of all payload bytes, excluding the header; the accumulator clears on accept and folds in each payload byte as it is accepted.
REQ-022 SHALL, on checksum accept, return to IDLE, pulse pkt_done for exactly one cycle, and increment sent_count (0xFFFF -> 0x0000).
REQ-023 SHALL give a minimum of 18 consecutive tx_valid cycles per packet with tx_ready=1, and at least one IDLE cycle between packets (19-cycle period back-to-back).
REQ-024 SHALL ignore pkt_valid outside IDLE; packets are never dropped or queued, since upstream holds pkt_valid.
REQ-025 SHALL keep tx_valid=0 in IDLE; tx_byte is don't-care there but driven to 8'h00.

Reset
REQ-026 SHALL, when rst=0 at a clk edge, set state=IDLE, tx_valid=0, tx_byte=0, pkt_done=0, sent_count=0, checksum=0, index=0, and pkt_ready=1 after reset release.
REQ-027 SHALL, on reset mid-packet, abandon the packet: tx_valid=0 the next cycle, no pkt_done pulse, and no count increment.

Structure
REQ-028 SHALL take HEADER_BYTE default, PKT_LEN=18, PAYLOAD_LEN=16 and the state enum from the shared package pkt_pkg, which the receiver uses too.
REQ-029 SHALL place the XOR accumulator (clear, enable, byte in, sum out) in sub-module pkt_checksum, which the receiver can reuse.

Verification
REQ-030 Stimulus: pkt_data=128'h4141504c696871ba006b69006a400000 with tx_ready=1. Response: bytes aa 41 41 50 4c 69 68 71 ba 00 6b 69 00 6a 40 00 00 fe; pkt_done one cycle later; sent_count=1.
REQ-031 Stimulus: payload 4141504c696871c0006b69006a400000 with tx_ready toggled randomly (stall). Response: identical byte sequence ending 84; no byte duplicated or skipped; tx_byte stable during stalls.
REQ-032 Stimulus: two packets with pkt_valid held continuously (payloads ...ba..., ...bb...). Response: checksums fe then ff; a 19-cycle period; pkt_ready=0 throughout each transmission.
REQ-033 Stimulus: rst=0 asserted after byte 7 is accepted. Response: tx_valid=0 next cycle; no pkt_done; sent_count unchanged; a new packet then transmits correctly from header.
REQ-034 Stimulus: pkt_data changed after accept. Response: transmitted bytes match the captured value.
REQ-035 Stimulus: sent_count preloaded via 65536 packets, or forced to 16'hFFFF, then one packet. Response: sent_count wraps to 16'h0000.
